// File: rtl/decoder_pkg.sv
// ============================================================================
// Module   : decoder_pkg
// Brief    : Shared mode and state encodings for the scanning decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package decoder_pkg;

   typedef enum logic [1:0] {
      DIRECT    = 2'b00,
      SCAN_UP   = 2'b01,
      SCAN_DOWN = 2'b10,
      SWEEP     = 2'b11
   } mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/onehot_decode.sv
// ============================================================================
// Module   : onehot_decode
// Brief    : Combinational index to one-hot line decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module onehot_decode #(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0]      idx,
   output logic [(1<<ADDR_W)-1:0] onehot
);

   for (genvar i = 0; i < (1 << ADDR_W); i++) begin : g_line
      assign onehot[i] = (idx == ADDR_W'(i));
   end

endmodule

`default_nettype wire

// File: rtl/decoder_scan.sv
// ============================================================================
// Module   : decoder_scan
// Brief    : Registered one-hot decoder with direct, scan and sweep modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decoder_scan
   import decoder_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int DWELL_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [1:0]               mode,
   input  logic [ADDR_W-1:0]        a,
   input  logic [DWELL_W-1:0]       dwell,
   input  logic                     start,
   output logic [(1<<ADDR_W)-1:0]   y,
   output logic [ADDR_W-1:0]        idx,
   output logic                     busy,
   output logic                     done
);

   localparam int OUT_W = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] c_idx_max = '1;

   state_t               r_state;
   mode_t                r_mode;
   logic [DWELL_W-1:0]   r_cnt;
   logic [DWELL_W-1:0]   r_dwell;

   state_t               w_state_nxt;
   mode_t                w_mode;
   mode_t                w_mode_nxt;
   logic [ADDR_W-1:0]    w_idx_nxt;
   logic [DWELL_W-1:0]   w_cnt_nxt;
   logic [DWELL_W-1:0]   w_dwell_nxt;
   logic                 w_y_on;
   logic                 w_done_nxt;
   logic [OUT_W-1:0]     w_dec;

   assign w_mode = mode_t'(mode);

   // The decoder looks at the next index so y lines up with idx.
   onehot_decode #(.ADDR_W(ADDR_W)) u_dec (
      .idx    (w_idx_nxt),
      .onehot (w_dec)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_idx_nxt   = idx;
      w_cnt_nxt   = r_cnt;
      w_dwell_nxt = r_dwell;
      w_y_on      = 1'b0;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_mode == DIRECT) begin
               w_idx_nxt = a;
               w_y_on    = en;
            end else if (start) begin
               w_state_nxt = RUN;
               w_mode_nxt  = w_mode;
               w_idx_nxt   = a;
               w_dwell_nxt = dwell;
               w_cnt_nxt   = '0;
               w_y_on      = en;
            end
         end
         RUN: begin
            // Any mode change aborts the scan without signalling completion.
            if (w_mode != r_mode) begin
               w_state_nxt = IDLE;
            end else if (en) begin
               w_y_on = 1'b1;
               if (r_cnt < r_dwell) begin
                  w_cnt_nxt = r_cnt + DWELL_W'(1);
               end else begin
                  w_cnt_nxt = '0;
                  case (r_mode)
                     SCAN_DOWN: w_idx_nxt = idx - ADDR_W'(1);
                     SWEEP: begin
                        if (idx == c_idx_max) begin
                           w_state_nxt = IDLE;
                           w_done_nxt  = 1'b1;
                           w_y_on      = 1'b0;
                        end else begin
                           w_idx_nxt = idx + ADDR_W'(1);
                        end
                     end
                     default:   w_idx_nxt = idx + ADDR_W'(1);
                  endcase
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_mode  <= DIRECT;
         r_cnt   <= '0;
         r_dwell <= '0;
         idx     <= '0;
         y       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dwell <= w_dwell_nxt;
         idx     <= w_idx_nxt;
         y       <= w_y_on ? w_dec : '0;
         busy    <= (w_state_nxt == RUN);
         done    <= w_done_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan.sv
// ============================================================================
// Module   : tb_decoder_scan
// Brief    : Scoreboard bench for decoder_scan with a behavioural line model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decoder_scan;

   localparam int ADDR_W  = 5;
   localparam int DWELL_W = 8;
   localparam int OUT_W   = 32;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 en    = 1'b0;
   logic [1:0]           mode  = 2'd0;
   logic [ADDR_W-1:0]    a     = '0;
   logic [DWELL_W-1:0]   dwell = '0;
   logic                 start = 1'b0;
   logic [OUT_W-1:0]     y;
   logic [ADDR_W-1:0]    idx;
   logic                 busy;
   logic                 done;

   decoder_scan #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .a     (a),
      .dwell (dwell),
      .start (start),
      .y     (y),
      .idx   (idx),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OUT_W-1:0] y;
      int               idx;
      bit               busy;
      bit               done;
      int               cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Model: which line is lit and how many enabled cycles it still has.
   bit   m_run   = 0;
   int   m_mode  = 0;
   int   m_idx   = 0;
   int   m_rem   = 0;
   int   m_dwell = 0;

   function automatic logic [OUT_W-1:0] line(input int i);
      logic [OUT_W-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic step();
      exp_t e;
      e.done = 0;
      if (!rst_n) begin
         m_run = 0;
         m_idx = 0;
         e.y   = '0;
      end else if (!m_run) begin
         if (mode == 2'd0) begin
            m_idx = int'(a);
            e.y   = en ? line(m_idx) : '0;
         end else if (start) begin
            m_run   = 1;
            m_mode  = int'(mode);
            m_idx   = int'(a);
            m_dwell = int'(dwell);
            m_rem   = m_dwell + 1;
            e.y     = en ? line(m_idx) : '0;
         end else begin
            e.y = '0;
         end
      end else if (int'(mode) != m_mode) begin
         m_run = 0;
         e.y   = '0;
      end else if (en) begin
         m_rem = m_rem - 1;
         if (m_rem == 0) begin
            m_rem = m_dwell + 1;
            case (m_mode)
               1: m_idx = (m_idx + 1) % OUT_W;
               2: m_idx = (m_idx + OUT_W - 1) % OUT_W;
               default: begin
                  if (m_idx == OUT_W - 1) begin
                     m_run  = 0;
                     e.done = 1;
                  end else begin
                     m_idx = m_idx + 1;
                  end
               end
            endcase
         end
         e.y = m_run ? line(m_idx) : '0;
      end else begin
         e.y = '0;
      end
      e.idx  = m_idx;
      e.busy = m_run;
      e.cyc  = cyc;
      q.push_back(e);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   exp_t mon_e;
   logic [ADDR_W-1:0] mon_idx;

   always @(posedge clk) begin
      #2;
      if (q.size() > 0) begin
         mon_e   = q.pop_front();
         mon_idx = mon_e.idx[ADDR_W-1:0];
         checks++;
         if (y !== mon_e.y || idx !== mon_idx || busy !== mon_e.busy || done !== mon_e.done) begin
            errors++;
            $display("FAIL outputs cyc=%0d: got y=%h idx=%0d busy=%b done=%b, expected y=%h idx=%0d busy=%b done=%b",
                     mon_e.cyc, y, idx, busy, done, mon_e.y, mon_idx, mon_e.busy, mon_e.done);
         end
         checks++;
         if ($countones(y) > 1) begin
            errors++;
            $display("FAIL onehot cyc=%0d: got y=%h, expected at most one bit set", mon_e.cyc, y);
         end
      end
   end

   initial begin
      // Reset, then release
      step();
      step();
      rst_n = 1'b1;

      // Direct decode
      mode = 2'd0; a = 5'd27; en = 1'b1;
      step();
      en = 1'b0;
      step();
      step();

      // Scan up across the wrap, then a start while running, then abort
      en = 1'b1; mode = 2'd1; a = 5'd30; dwell = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) step();
      start = 1'b1; a = 5'd5;
      step();
      start = 1'b0;
      step();
      mode = 2'd0;
      step();
      step();

      // Sweep to the top, with a start landing on the done cycle
      mode = 2'd3; a = 5'd29; dwell = 8'd2; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         start = (k == 9);
         step();
      end
      start = 1'b0;

      // Scan down with a pause mid-line
      mode = 2'd2; a = 5'd1; dwell = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      en = 1'b0;
      for (int k = 0; k < 4; k++) step();
      en = 1'b1;
      for (int k = 0; k < 5; k++) step();
      mode = 2'd0;
      step();

      // Asynchronous reset mid-sweep
      mode = 2'd3; a = 5'd10; dwell = 8'd3; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 5; k++) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (y !== '0 || idx !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got y=%h idx=%0d busy=%b done=%b, expected all zero", y, idx, busy, done);
      end
      m_run = 0;
      m_idx = 0;
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) step();

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 24) == 0) mode = 2'($urandom);
         start = ($urandom_range(0, 7) == 0);
         en    = ($urandom_range(0, 5) != 0);
         a     = 5'($urandom);
         dwell = 8'($urandom_range(0, 3));
         step();
      end

      start = 1'b0;
      @(posedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
